// File: rtl/aes_core_arbiter_if.sv
// Requester-side bus of aes_core_arbiter: per-requester request/accept and
// response/accept handshakes plus the shared result block.
interface aes_core_arbiter_if #(
   parameter int NUM_REQ = 2
);
   logic [NUM_REQ-1:0]     req_valid;
   logic [NUM_REQ-1:0]     req_ready;
   logic [NUM_REQ-1:0]     req_mode;
   logic [NUM_REQ*128-1:0] req_key;
   logic [NUM_REQ*128-1:0] req_data;
   logic [NUM_REQ-1:0]     rsp_valid;
   logic [NUM_REQ-1:0]     rsp_ready;
   logic [127:0]           rsp_data;
   logic                   rsp_error;

   modport master (
      output req_valid, req_mode, req_key, req_data, rsp_ready,
      input  req_ready, rsp_valid, rsp_data, rsp_error
   );

   modport slave (
      input  req_valid, req_mode, req_key, req_data, rsp_ready,
      output req_ready, rsp_valid, rsp_data, rsp_error
   );
endinterface

// File: rtl/aes_core_arbiter.sv
// Round-robin arbiter sharing one iterative AES-128 core between NUM_REQ requesters.
// Define AES_ARB_TIMEOUT_EN to add the WAIT watchdog (core_abort / rsp_error).
module aes_core_arbiter #(
   parameter int NUM_REQ        = 2,
   parameter int GID_W          = 1,
   parameter int TIMEOUT_CYCLES = 1023
) (
   input  logic                 clk,
   input  logic                 rst_n,
   aes_core_arbiter_if.slave    bus,
   output logic                 core_start,
   output logic                 core_mode,
   output logic [127:0]         core_key,
   output logic [127:0]         core_din,
   input  logic                 core_done,
   input  logic [127:0]         core_dout,
   output logic                 core_abort,
   output logic                 busy,
   output logic [GID_W-1:0]     grant_id,
   output logic [15:0]          op_count
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } state_e;

   state_e             state_q, state_d;
   logic [GID_W-1:0]   grant_q, grant_d;
   logic [GID_W-1:0]   last_q, last_d;
   logic [127:0]       key_q, key_d;
   logic [127:0]       data_q, data_d;
   logic               mode_q, mode_d;
   logic [127:0]       rsp_data_q, rsp_data_d;
   logic [15:0]        op_cnt_q, op_cnt_d;

`ifdef AES_ARB_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [CNT_W-1:0]   wd_q, wd_d;
   logic               rsp_err_q, rsp_err_d;
`endif

   // Round-robin pick: first valid requester above the last one served.
   logic               any_valid;
   logic [GID_W-1:0]   pick;
   int                 idx;

   always_comb begin
      // NOTE: every combinational output gets a default first so no latch is inferred.
      any_valid = 1'b0;
      pick      = '0;
      idx       = 0;
      for (int k = 0; k < NUM_REQ; k++) begin
         idx = (int'(last_q) + 1 + k) % NUM_REQ;
         if (!any_valid && bus.req_valid[idx]) begin
            any_valid = 1'b1;
            pick      = GID_W'(idx);
         end
      end
   end

   always_comb begin
      state_d       = state_q;
      grant_d       = grant_q;
      last_d        = last_q;
      key_d         = key_q;
      data_d        = data_q;
      mode_d        = mode_q;
      rsp_data_d    = rsp_data_q;
      op_cnt_d      = op_cnt_q;
      bus.req_ready = '0;
      bus.rsp_valid = '0;
      core_start    = 1'b0;
      core_abort    = 1'b0;
`ifdef AES_ARB_TIMEOUT_EN
      wd_d          = wd_q;
      rsp_err_d     = rsp_err_q;
`endif

      case (state_q)
         IDLE: begin
            if (any_valid) begin
               bus.req_ready[pick] = 1'b1;
               grant_d             = pick;
               key_d               = bus.req_key[int'(pick)*128 +: 128];
               data_d              = bus.req_data[int'(pick)*128 +: 128];
               mode_d              = bus.req_mode[pick];
               state_d             = ISSUE;
            end
         end

         ISSUE: begin
            core_start = 1'b1;
            state_d    = WAIT;
`ifdef AES_ARB_TIMEOUT_EN
            wd_d       = '0;
`endif
         end

         WAIT: begin
            // A done arriving in the timeout cycle still counts as a normal result.
            if (core_done) begin
               rsp_data_d = core_dout;
`ifdef AES_ARB_TIMEOUT_EN
               rsp_err_d  = 1'b0;
`endif
               state_d    = RESP;
            end
`ifdef AES_ARB_TIMEOUT_EN
            else if (wd_q == CNT_W'(TIMEOUT_CYCLES)) begin
               core_abort = 1'b1;
               rsp_data_d = '0;
               rsp_err_d  = 1'b1;
               state_d    = RESP;
            end else begin
               wd_d = wd_q + 1'b1;
            end
`endif
         end

         RESP: begin
            bus.rsp_valid[grant_q] = 1'b1;
            if (bus.rsp_ready[grant_q]) begin
               last_d   = grant_q;
               op_cnt_d = op_cnt_q + 16'd1;
               state_d  = IDLE;
            end
         end

         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
      if (!rst_n) begin
         state_q    <= IDLE;
         grant_q    <= '0;
         last_q     <= GID_W'(NUM_REQ - 1);
         key_q      <= '0;
         data_q     <= '0;
         mode_q     <= 1'b0;
         rsp_data_q <= '0;
         op_cnt_q   <= '0;
`ifdef AES_ARB_TIMEOUT_EN
         wd_q       <= '0;
         rsp_err_q  <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         grant_q    <= grant_d;
         last_q     <= last_d;
         key_q      <= key_d;
         data_q     <= data_d;
         mode_q     <= mode_d;
         rsp_data_q <= rsp_data_d;
         op_cnt_q   <= op_cnt_d;
`ifdef AES_ARB_TIMEOUT_EN
         wd_q       <= wd_d;
         rsp_err_q  <= rsp_err_d;
`endif
      end
   end

   assign core_key     = key_q;
   assign core_din     = data_q;
   assign core_mode    = mode_q;
   assign busy         = (state_q != IDLE);
   assign grant_id     = grant_q;
   assign op_count     = op_cnt_q;
   assign bus.rsp_data = rsp_data_q;
`ifdef AES_ARB_TIMEOUT_EN
   assign bus.rsp_error = rsp_err_q;
`else
   assign bus.rsp_error = 1'b0;
`endif

endmodule

// File: tb/tb_aes_core_arbiter.sv
// Scoreboard bench for aes_core_arbiter with a table-driven behavioural AES core.
module tb_aes_core_arbiter;
   localparam int NR  = 2;
   localparam int GW  = 1;
   localparam int TO  = 20;
   localparam int LAT = 11;
   localparam logic [127:0] K = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] P = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] C = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   aes_core_arbiter_if #(.NUM_REQ(NR)) bus ();

   logic          core_start, core_mode, core_abort, busy;
   logic          core_done = 1'b0;
   logic [127:0]  core_key, core_din;
   logic [127:0]  core_dout = '0;
   logic [GW-1:0] grant_id;
   logic [15:0]   op_count;

   aes_core_arbiter #(.NUM_REQ(NR), .GID_W(GW), .TIMEOUT_CYCLES(TO)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .bus        (bus.slave),
      .core_start (core_start),
      .core_mode  (core_mode),
      .core_key   (core_key),
      .core_din   (core_din),
      .core_done  (core_done),
      .core_dout  (core_dout),
      .core_abort (core_abort),
      .busy       (busy),
      .grant_id   (grant_id),
      .op_count   (op_count)
   );

   int total = 0;
   int bad   = 0;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Behavioural core: known FIPS-197 vectors, otherwise a simple mix.
   function automatic logic [127:0] core_fn(input logic [127:0] k, input logic [127:0] d, input logic m);
      if (m && k == K && d == P) return C;
      if (!m && k == K && d == C) return P;
      return d ^ k ^ {128{m}};
   endfunction

   logic [127:0] m_key = '0, m_din = '0;
   logic         m_mode = 1'b0;
   int           m_cnt = 0;
   int           start_count = 0;
   bit           no_done = 0;
   bit           abort_seen = 0;

   always @(posedge clk) begin
      core_done <= 1'b0;
      if (core_start === 1'b1) begin
         m_key       <= core_key;
         m_din       <= core_din;
         m_mode      <= core_mode;
         m_cnt       <= LAT;
         start_count <= start_count + 1;
      end else if (m_cnt > 0) begin
         m_cnt <= m_cnt - 1;
         if (m_cnt == 1 && !no_done) begin
            core_done <= 1'b1;
            core_dout <= core_fn(m_key, m_din, m_mode);
         end
      end
   end

   always @(negedge clk) begin
      if (core_abort === 1'b1) abort_seen = 1;
      if (core_done && busy) begin
         check("core_key_stable", core_key, m_key);
         check("core_din_stable", core_din, m_din);
         check("core_mode_stable", 128'(core_mode), 128'(m_mode));
      end
   end

   // Scoreboard monitor.
   typedef struct packed {
      logic [GW-1:0] gid;
      logic [127:0]  data;
      logic          err;
   } exp_t;
   exp_t exp_q[$];
   bit   rsp_seen = 0;

   task automatic push_exp(input int gid, input logic [127:0] data, input logic err);
      exp_t e;
      e.gid  = GW'(gid);
      e.data = data;
      e.err  = err;
      exp_q.push_back(e);
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (bus.rsp_valid != '0) begin
         if (!rsp_seen) begin
            rsp_seen = 1;
            if (exp_q.size() == 0) begin
               check("rsp_unexpected", 128'(bus.rsp_valid), 128'(0));
            end else begin
               e = exp_q.pop_front();
               check("rsp_valid_owner", 128'(bus.rsp_valid), 128'(NR'(1) << e.gid));
               check("rsp_grant_id", 128'(grant_id), 128'(e.gid));
               check("rsp_data", bus.rsp_data, e.data);
               check("rsp_error", 128'(bus.rsp_error), 128'(e.err));
            end
         end
      end else begin
         rsp_seen = 0;
      end
   end

   task automatic set_req(input int r, input logic m, input logic [127:0] k, input logic [127:0] d);
      bus.req_mode[r]           = m;
      bus.req_key[r*128 +: 128]  = k;
      bus.req_data[r*128 +: 128] = d;
   endtask

   // Call at posedge+1; returns at posedge+1 of the cycle after acceptance.
   task automatic wait_accept(input logic [NR-1:0] exp_rdy, input string name, input int max_cyc);
      for (int i = 0; i < max_cyc; i++) begin
         @(negedge clk);
         if (bus.req_ready != '0) break;
      end
      check({name, "_req_ready"}, 128'(bus.req_ready), 128'(exp_rdy));
      @(posedge clk);
      #1;
   endtask

   task automatic wait_rsp(input logic [NR-1:0] exp_v, input string name);
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (bus.rsp_valid != '0) break;
      end
      check({name, "_rsp_arrive"}, 128'(bus.rsp_valid), 128'(exp_v));
   endtask

   task automatic handshake(input logic [NR-1:0] rdy);
      bus.rsp_ready = rdy;
      @(posedge clk);
      #1;
      bus.rsp_ready = '0;
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1;
      rst_n         = 1'b0;
      bus.req_valid = '0;
      bus.rsp_ready = '0;
      @(posedge clk);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int base;
      int order [4] = '{0, 1, 0, 1};
      bus.req_valid = '0;
      bus.req_mode  = '0;
      bus.req_key   = '0;
      bus.req_data  = '0;
      bus.rsp_ready = '0;

      // Reset state.
      do_reset();
      @(negedge clk);
      check("rst_busy", 128'(busy), 128'(0));
      check("rst_rsp_valid", 128'(bus.rsp_valid), 128'(0));
      check("rst_op_count", 128'(op_count), 128'(0));
      check("rst_grant_id", 128'(grant_id), 128'(0));
      check("rst_core_key", core_key, 128'(0));
      check("rst_core_din", core_din, 128'(0));
      check("rst_rsp_data", bus.rsp_data, 128'(0));
      check("rst_core_start", 128'(core_start), 128'(0));

      // Single encrypt with backpressure; requester 1 queues a decrypt meanwhile.
      @(posedge clk);
      #1;
      base = start_count;
      set_req(0, 1'b1, K, P);
      push_exp(0, C, 1'b0);
      bus.req_valid[0] = 1'b1;
      wait_accept(2'b01, "enc", 50);
      bus.req_valid[0] = 1'b0;
      @(negedge clk);
      check("issue_core_start", 128'(core_start), 128'(1));
      check("issue_core_key", core_key, K);
      check("issue_core_din", core_din, P);
      check("issue_core_mode", 128'(core_mode), 128'(1));
      set_req(1, 1'b0, K, C);
      push_exp(1, P, 1'b0);
      bus.req_valid[1] = 1'b1;
      wait_rsp(2'b01, "enc");
      bus.rsp_ready = 2'b10;
      for (int i = 0; i < 10; i++) begin
         check("bp_rsp_valid", 128'(bus.rsp_valid), 128'(2'b01));
         check("bp_rsp_data", bus.rsp_data, C);
         check("bp_busy", 128'(busy), 128'(1));
         check("bp_req_ready", 128'(bus.req_ready), 128'(0));
         check("bp_single_start", 128'(start_count - base), 128'(1));
         @(negedge clk);
      end
      handshake(2'b01);
      wait_accept(2'b10, "dec_next", 1);
      bus.req_valid[1] = 1'b0;
      bus.req_data[128 +: 128] = '0;
      @(negedge clk);
      check("dec_op_count", 128'(op_count), 128'(1));
      check("dec_core_din", core_din, C);
      check("dec_core_mode", 128'(core_mode), 128'(0));
      check("dec_grant_id", 128'(grant_id), 128'(1));
      wait_rsp(2'b10, "dec");
      handshake(2'b10);
      @(negedge clk);
      check("dec_done_op_count", 128'(op_count), 128'(2));
      check("dec_done_starts", 128'(start_count - base), 128'(2));

      // Both requesters held valid after reset: grants alternate from 0.
      do_reset();
      set_req(0, 1'b1, K, P);
      set_req(1, 1'b0, K, C);
      bus.req_valid = 2'b11;
      for (int k = 0; k < 4; k++) begin
         push_exp(order[k], (order[k] == 0) ? C : P, 1'b0);
         wait_accept(NR'(1) << order[k], "rr", 50);
         wait_rsp(NR'(1) << order[k], "rr");
         handshake(2'b11);
      end
      bus.req_valid = '0;
      @(negedge clk);
      check("rr_op_count", 128'(op_count), 128'(4));

      // Requester 0 completes, then requester 1 is reset mid-WAIT.
      @(posedge clk);
      #1;
      set_req(0, 1'b1, K, P);
      push_exp(0, C, 1'b0);
      bus.req_valid[0] = 1'b1;
      wait_accept(2'b01, "pre", 50);
      bus.req_valid[0] = 1'b0;
      wait_rsp(2'b01, "pre");
      handshake(2'b01);
      set_req(1, 1'b1, K, P);
      bus.req_valid[1] = 1'b1;
      wait_accept(2'b10, "mid", 50);
      bus.req_valid[1] = 1'b0;
      @(negedge clk);
      check("mid_core_start", 128'(core_start), 128'(1));
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(negedge clk);
      check("mid_rst_busy", 128'(busy), 128'(0));
      check("mid_rst_rsp_valid", 128'(bus.rsp_valid), 128'(0));
      check("mid_rst_op_count", 128'(op_count), 128'(0));
      repeat (15) @(negedge clk);
      check("late_done_busy", 128'(busy), 128'(0));
      check("late_done_rsp_valid", 128'(bus.rsp_valid), 128'(0));
      @(posedge clk);
      #1;
      push_exp(0, C, 1'b0);
      bus.req_valid = 2'b11;
      wait_accept(2'b01, "post_rst", 50);
      bus.req_valid = '0;
      wait_rsp(2'b01, "post_rst");
      handshake(2'b01);
      @(negedge clk);
      check("post_rst_op_count", 128'(op_count), 128'(1));

`ifdef AES_ARB_TIMEOUT_EN
      begin
         int n;
         n = 0;
         no_done = 1;
         @(posedge clk);
         #1;
         set_req(0, 1'b1, K, P);
         push_exp(0, 128'(0), 1'b1);
         bus.req_valid[0] = 1'b1;
         wait_accept(2'b01, "to", 50);
         bus.req_valid[0] = 1'b0;
         @(negedge clk);
         for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (core_abort === 1'b1) begin
               n = i;
               break;
            end
         end
         check("to_abort_delay", 128'(n), 128'(TO + 1));
         @(negedge clk);
         check("to_abort_pulse", 128'(core_abort), 128'(0));
         check("to_rsp_valid", 128'(bus.rsp_valid), 128'(2'b01));
         handshake(2'b01);
         @(negedge clk);
         check("to_op_count", 128'(op_count), 128'(2));
         no_done = 0;
      end
`else
      check("no_abort", 128'(abort_seen), 128'(0));
`endif

      repeat (3) @(negedge clk);
      check("scoreboard_drained", 128'(exp_q.size()), 128'(0));
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/aes_core_arbiter.md
Name: aes_core_arbiter

Overview:
- Shares one iterative AES-128 core between NUM_REQ requesters, e.g. the button/switch front end and a UART command path on the FPGA top.
- Accepts one request at a time using round-robin priority and latches its key, data and mode.
- Sequences the core through a start/done handshake and returns the result to the granted requester with a valid/ready handshake.

Parameters:
- NUM_REQ, 2, number of requesters (2..4).
- GID_W, 1, width of grant index; must equal clog2(NUM_REQ), minimum 1.
- TIMEOUT_CYCLES, 1023, watchdog limit in cycles; used only with AES_ARB_TIMEOUT_EN.

Ports:
- clk  in  1  system clock, 100 MHz.
- rst_n  in  1  reset; synchronous, active-low.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_ready  out  NUM_REQ  one-cycle accept pulse to the chosen requester.
- req_mode  in  NUM_REQ  per-requester mode; 1=encrypt, 0=decrypt.
- req_key  in  NUM_REQ*128  packed keys; requester i occupies bits [i*128 +: 128].
- req_data  in  NUM_REQ*128  packed input blocks, same packing.
- rsp_valid  out  NUM_REQ  result valid, one-hot to the owner.
- rsp_ready  in  NUM_REQ  result accept from each requester.
- rsp_data  out  128  result block, shared by all requesters.
- rsp_error  out  1  result is invalid (timeout); qualified by rsp_valid.
- core_start  out  1  one-cycle start pulse to the AES core.
- core_mode  out  1  mode to the core.
- core_key  out  128  key to the core.
- core_din  out  128  input block to the core.
- core_done  in  1  core completion pulse.
- core_dout  in  128  core result; valid while core_done=1.
- core_abort  out  1  one-cycle abort pulse to the core.
- busy  out  1  high in any state other than IDLE.
- grant_id  out  GID_W  index of the current owner.
- op_count  out  16  count of completed operations.

Behaviour:
- Reset (rst_n=0 sampled at a clk edge):
  - State goes to IDLE.
  - All outputs are 0, including latched key/data/mode, rsp_data and op_count.
  - last_grant is set to NUM_REQ-1, so requester 0 wins the first arbitration.
  - Reset mid-operation abandons the operation silently; no response is issued and core_abort is not pulsed.
- State machine: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
- IDLE:
  - If any req_valid bit is set, grant g = the first valid index searching upward from last_grant+1, modulo NUM_REQ.
  - In the same cycle, req_ready[g]=1 (combinational from state and req_valid), and the key, data and mode of g plus grant_id are latched at the edge.
  - Next state is ISSUE.
  - If no request is valid, stay in IDLE.
- ISSUE:
  - core_start=1 for exactly this cycle; core_key, core_din and core_mode are driven from the latches.
  - Next state is WAIT.
- WAIT:
  - On core_done=1, latch core_dout into rsp_data, set rsp_error=0, go to RESP.
  - core_done is ignored in every state except WAIT.
- RESP:
  - rsp_valid[grant_id]=1; rsp_data and rsp_error are held stable until rsp_ready[grant_id]=1.
  - On that handshake: last_grant<=grant_id, op_count increments (wrapping 0xFFFF->0), next state is IDLE.
  - rsp_ready on non-owner bits is ignored.
- Latency: request accepted at cycle T, core_start at T+1, rsp_valid at D+1 where D is the core_done cycle. The earliest next accept is the cycle after the response handshake.
- Simultaneous events:
  - Requests arriving during ISSUE, WAIT or RESP are not accepted; req_ready stays 0.
  - A requester may drop req_valid before it is accepted, with no side effect.
  - A change to the inputs of an already accepted requester does not affect the operation in flight.
- Fairness: a requester that stays valid is served within NUM_REQ operations.
- core_mode, core_key and core_din stay stable from ISSUE through the end of WAIT.

Optional Feature:
- Macro: AES_ARB_TIMEOUT_EN.
- With the macro defined:
  - A cycle counter clears on entry to WAIT and increments each WAIT cycle.
  - If it reaches TIMEOUT_CYCLES without core_done, core_abort=1 for one cycle, rsp_data=0, rsp_error=1, and the state goes to RESP.
  - op_count still increments on the response handshake.
  - core_done in the same cycle as the timeout wins: the response is normal.
- Without the macro: there is no counter, core_abort and rsp_error are tied to 0, and WAIT waits indefinitely.

Test Plan:
- Single encrypt: req_valid=01, req0 key=000102030405060708090a0b0c0d0e0f, data=00112233445566778899aabbccddeeff, mode=1, with a behavioural core model.
  -> Exactly one core_start; rsp_valid=01; rsp_data=69c4e0d86a7b0430d8cdb78070b4c55a; op_count=1.
- Simultaneous requests after reset: req_valid=11 held.
  -> Grant order is 0, 1, 0, 1 over four operations; grant_id matches each rsp_valid bit.
- Backpressure: rsp_ready=0 for 10 cycles after rsp_valid.
  -> rsp_valid and rsp_data stay constant, busy=1, req_ready=00, and no second core_start.
- Decrypt round-trip: req1 mode=0, data=69c4e0d86a7b0430d8cdb78070b4c55a, same key.
  -> rsp_valid=10; rsp_data=00112233445566778899aabbccddeeff.
- Reset mid-WAIT: rst_n=0 for one cycle, 3 cycles after core_start.
  -> Next cycle: state IDLE, rsp_valid=00, busy=0, op_count=0; a late core_done is ignored; the next request goes to req0.
- Timeout (AES_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=20): the core never asserts core_done.
  -> core_abort pulses 20 cycles after entering WAIT; rsp_error=1; rsp_data=0.
